// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and MMIO register addresses for the UART TX path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  localparam logic [31:0] UART_MMIO_WEA_ADDR = 32'hAAAAA004;
  localparam logic [31:0] UART_MMIO_DAT_ADDR = 32'hAAAAA008;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign dout  = mem_q[rd_q];
  assign count = count_q;
  always_comb begin
    rd_en   = pop & ~empty;
    wr_en   = push & (~full | rd_en);
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(rd_en);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-fed UART transmitter, byte FIFO plus 8N1 LSB-first serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (11-bit frame).
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          Rst_n,
  input  logic                          mmio_wea,
  input  logic [31:0]                   mmio_dat,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow
);
  import uart_pkg::*;
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  uart_tx_state_e state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d, fifo_dout;
  logic           wea_q, tx_q, tx_d, ovf_q, ovf_d;
  logic           push, pop, bit_end, fifo_empty, unused_hi;
  assign unused_hi   = ^mmio_dat[31:8];
  assign tx          = tx_q;
  assign tx_busy     = state_q != IDLE;
  assign tx_overflow = ovf_q;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .Rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .din   (mmio_dat[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  // The shift register rotates rather than shifts, so after the last data bit it still
  // holds a permutation of the byte and its XOR is the even-parity bit.
  always_comb begin
    push    = mmio_wea & ~wea_q;
    pop     = (state_q == IDLE) & ~fifo_empty;
    ovf_d   = ovf_q | (push & fifo_full & ~pop);
    bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: if (pop) begin
        shift_d = fifo_dout;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (bit_end) begin
        tx_d    = shift_q[0];
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          tx_d    = PAR_EN ? ^shift_q : 1'b1;
          state_d = PAR_EN ? PARITY : STOP;
        end else begin
          shift_d = {shift_q[0], shift_q[7:1]};
          tx_d    = shift_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: if (bit_end) begin
        tx_d    = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wea_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wea_q   <= mmio_wea;
    end
  end
endmodule
